// File: rtl/instr_fetch.sv
// Instruction fetch unit: a small register-file instruction memory that is loaded while idle,
// then streams words to the CPU one at a time until a zero word or the last address is reached.
module instr_fetch #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          start,
    input  logic          redir_en,
    input  logic [AW-1:0] redir_pc,
    input  logic          instr_rdy,
    output logic [31:0]   instr,
    output logic          instr_vld,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

    state_t                 state_q, state_d;
    logic [DEPTH-1:0][31:0] mem_q;
    logic [AW-1:0]          pc_q, pc_d;
    logic [31:0]            instr_q, instr_d;
    logic                   vld_q, vld_d;
    logic [31:0]            fetch_word;

    assign fetch_word = mem_q[pc_q];

    // Memory has no reset so a loaded program survives a CPU reset.
    always_ff @(posedge clk) begin
        if (ld_en && !busy) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (redir_en)              state_d = S_FETCH;
                else if (fetch_word == '0) state_d = S_HALT;
                else                       state_d = S_HOLD;
            end
            S_HOLD: begin
                if (redir_en)       state_d = S_FETCH;
                else if (instr_rdy) state_d = (pc_q == LAST_PC) ? S_HALT : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values; instr_vld is registered so it rises on the same edge instr loads.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) pc_d = '0;
            end
            S_FETCH: begin
                if (redir_en) begin
                    pc_d = redir_pc;
                end else begin
                    instr_d = fetch_word;
                    vld_d   = (fetch_word != '0);
                end
            end
            S_HOLD: begin
                if (redir_en) begin
                    pc_d = redir_pc;
                end else if (instr_rdy) begin
                    // Last word accepted: stop at the top address instead of wrapping.
                    if (pc_q != LAST_PC) pc_d = pc_q + AW'(1);
                end else begin
                    vld_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy   = (state_q == S_FETCH) || (state_q == S_HOLD);
        halted = (state_q == S_HALT);
    end

    assign instr     = instr_q;
    assign instr_vld = vld_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed programs with literal checks, plus a transaction-level
// model of the fetch stream compared against the outputs every cycle.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        start = 1'b0;
    logic        redir_en = 1'b0;
    logic [3:0]  redir_pc = '0;
    logic        instr_rdy = 1'b0;
    logic [31:0] instr;
    logic        instr_vld;
    logic [3:0]  pc;
    logic        busy;
    logic        halted;

    int checks = 0;
    int errors = 0;

    instr_fetch #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .redir_en(redir_en), .redir_pc(redir_pc), .instr_rdy(instr_rdy),
        .instr(instr), .instr_vld(instr_vld), .pc(pc), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] val(input int i);
        return 32'h1000_0000 + 32'(i * 3 + 1);
    endfunction

    // Model: the unit is either waiting for a word to be read (m_fetch), offering one (m_pres),
    // stopped (m_halt), or idle; m_pc is the address it is working on.
    logic [31:0] mem_m [16];
    logic        m_fetch = 1'b0, m_pres = 1'b0, m_halt = 1'b0, m_busy;
    logic [3:0]  m_pc = '0;
    logic [31:0] m_instr = '0;

    initial for (int i = 0; i < 16; i++) mem_m[i] = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_fetch = 1'b0; m_pres = 1'b0; m_halt = 1'b0; m_pc = '0;
        end else begin
            m_busy = m_fetch || m_pres;
            if (ld_en && !m_busy) mem_m[ld_addr] = ld_data;
            if (m_busy && redir_en) begin
                m_pc = redir_pc; m_fetch = 1'b1; m_pres = 1'b0;
            end else if (m_fetch) begin
                m_fetch = 1'b0;
                if (mem_m[m_pc] == 32'h0) m_halt = 1'b1;
                else begin m_pres = 1'b1; m_instr = mem_m[m_pc]; end
            end else if (m_pres && instr_rdy) begin
                m_pres = 1'b0;
                if (m_pc == 4'd15) m_halt = 1'b1;
                else begin m_pc = m_pc + 4'd1; m_fetch = 1'b1; end
            end else if (!m_busy && start) begin
                m_pc = '0; m_fetch = 1'b1; m_halt = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_vld", instr_vld, m_pres);
        chk("m_busy", busy, m_fetch || m_pres);
        chk("m_halted", halted, m_halt);
        chk("m_pc", pc, m_pc);
        if (m_pres) chk("m_instr", instr, m_instr);
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    initial begin
        int cnt;
        #3;
        chk("rst_vld", instr_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Three-word program ending in a zero word, CPU always ready
        load(4'd0, 32'h002081B3);
        load(4'd1, 32'h06320813);
        load(4'd2, 32'h0);
        instr_rdy = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        chk("t1_fetch_vld", instr_vld, 0);
        step();
        chk("t1_w0_vld", instr_vld, 1);
        chk("t1_w0_instr", instr, 32'h002081B3);
        chk("t1_w0_pc", pc, 0);
        step();
        chk("t1_gap_vld", instr_vld, 0);
        step();
        chk("t1_w1_vld", instr_vld, 1);
        chk("t1_w1_instr", instr, 32'h06320813);
        chk("t1_w1_pc", pc, 1);
        step(2);
        chk("t1_halted", halted, 1);
        chk("t1_halt_pc", pc, 2);
        chk("t1_halt_vld", instr_vld, 0);

        // Same program with the CPU stalling for 5 cycles on the first word
        instr_rdy = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_vld", instr_vld, 1);
            chk("t2_stall_instr", instr, 32'h002081B3);
            chk("t2_stall_pc", pc, 0);
            if (i < 4) step();
        end
        instr_rdy = 1'b1;
        step();
        chk("t2_adv_vld", instr_vld, 0);
        chk("t2_adv_pc", pc, 1);
        step();
        chk("t2_w1_instr", instr, 32'h06320813);
        step(2);
        chk("t2_halted", halted, 1);

        // Full memory of nonzero words: 16 presentations, stop at the top without wrapping
        for (int i = 0; i < 16; i++) load(4'(i), val(i));
        instr_rdy = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (instr_vld) begin
                chk("t3_instr", instr, (cnt < 16) ? val(cnt) : 32'hFFFF_FFFF);
                chk("t3_pc", pc, 32'(cnt));
                cnt++;
            end
            if (halted) break;
            step();
        end
        chk("t3_count", cnt, 16);
        chk("t3_halted", halted, 1);
        chk("t3_pc_top", pc, 15);
        step(2);
        chk("t3_pc_hold", pc, 15);

        // Redirect from HOLD at pc 1 to pc 5, winning over instr_rdy
        instr_rdy = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        step();
        instr_rdy = 1'b1;
        step();
        instr_rdy = 1'b0;
        step();
        chk("t4_hold_pc", pc, 1);
        chk("t4_hold_vld", instr_vld, 1);
        redir_en = 1'b1; redir_pc = 4'd5; instr_rdy = 1'b1;
        step();
        redir_en = 1'b0; instr_rdy = 1'b0;
        chk("t4_redir_vld", instr_vld, 0);
        chk("t4_redir_pc", pc, 5);
        step();
        chk("t4_w5_vld", instr_vld, 1);
        chk("t4_w5_instr", instr, val(5));
        chk("t4_w5_pc", pc, 5);

        // Load attempt while busy is dropped; reset between edges clears outputs at once
        ld_en = 1'b1; ld_addr = 4'd5; ld_data = 32'hDEADBEEF;
        step(); ld_en = 1'b0;
        chk("t5_still_hold", instr, val(5));
        #2; rst = 1'b0; #1;
        chk("t5_async_vld", instr_vld, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_pc", pc, 0);
        chk("t5_async_instr", instr, 0);
        chk("t5_async_halted", halted, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        redir_en = 1'b1; redir_pc = 4'd7;
        step(); redir_en = 1'b0;
        chk("t5_idle_redir_busy", busy, 0);
        chk("t5_idle_redir_pc", pc, 0);
        step();
        chk("t5_no_present", instr_vld, 0);
        start = 1'b1;
        step(); start = 1'b0;
        redir_en = 1'b1; redir_pc = 4'd5;
        step(); redir_en = 1'b0;
        chk("t5_redir_pc", pc, 5);
        step();
        chk("t5_mem5_kept", instr, val(5));

        // Load and start on the same edge from IDLE; start while busy is ignored
        rst = 1'b0;
        step(); rst = 1'b1;
        ld_en = 1'b1; ld_addr = 4'd0; ld_data = 32'h00000013; start = 1'b1; instr_rdy = 1'b0;
        step(); ld_en = 1'b0; start = 1'b0;
        step();
        chk("t6_new_word", instr, 32'h00000013);
        chk("t6_new_pc", pc, 0);
        start = 1'b1;
        step(); start = 1'b0;
        chk("t6_busy_start_pc", pc, 0);
        chk("t6_busy_start_vld", instr_vld, 1);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: DEPTH, 16, number of 32-bit instruction words held.
REQ-002 Parameter: AW, 4, PC/address width; SHALL equal clog2(DEPTH).
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 Port: ld_en  input  1  write ld_data into instruction memory at ld_addr.
REQ-006 Port: ld_addr  input  AW  memory write address.
REQ-007 Port: ld_data  input  32  memory write data (RV32 encoding).
REQ-008 Port: start  input  1  begin fetching from PC 0.
REQ-009 Port: redir_en  input  1  redirect fetch (branch/jump target).
REQ-010 Port: redir_pc  input  AW  redirect target word address.
REQ-011 Port: instr_rdy  input  1  CPU accepts presented instruction.
REQ-012 Port: instr  output  32  instruction word to CPU instruction input.
REQ-013 Port: instr_vld  output  1  instr holds a valid instruction.
REQ-014 Port: pc  output  AW  word address of instruction being fetched/presented.
REQ-015 Port: busy  output  1  high in FETCH or HOLD.
REQ-016 Port: halted  output  1  high in HALT.

Function
REQ-017 SHALL contain DEPTH x 32 register-based memory, synchronous write, contents not cleared by reset.
REQ-018 ld_en SHALL write only when busy=0; ld_en while busy=1 SHALL be ignored (memory unchanged).
REQ-019 FSM states: IDLE, FETCH, HOLD, HALT.
REQ-020 IDLE: instr_vld=0; start=1 -> pc=0, go FETCH.
REQ-021 FETCH (exactly one cycle): instr register loads mem[pc]; if mem[pc]==32'h0 -> HALT with instr_vld staying 0; else -> HOLD with instr_vld=1 on the same edge.
REQ-022 Latency: start sampled at edge k -> instr_vld=1 and instr=mem[0] after edge k+1.
REQ-023 HOLD: instr and pc SHALL stay stable while instr_vld=1 and instr_rdy=0.
REQ-024 HOLD with instr_rdy=1: pc==DEPTH-1 -> HALT, instr_vld=0 (no wrap-around); else pc=pc+1, go FETCH, instr_vld=0.
REQ-025 Sustained throughput: one instruction per 2 cycles with instr_rdy held high.
REQ-026 redir_en=1 in FETCH or HOLD: pc=redir_pc, go FETCH, instr_vld=0; takes priority over instr_rdy and zero-word halt detection in the same cycle.
REQ-027 redir_en in IDLE or HALT SHALL be ignored.
REQ-028 HALT: halted=1, instr_vld=0, pc holds last value; start=1 -> pc=0, go FETCH.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 Simultaneous ld_en and start in IDLE/HALT: write completes on that edge; FETCH of pc 0 in the next cycle reads the new data.

Reset
REQ-031 rst=0 SHALL immediately (no clock) force: state=IDLE, pc=0, instr=32'h0, instr_vld=0, busy=0, halted=0.
REQ-032 Reset asserted mid-fetch SHALL abandon the transfer; no instruction is presented after release until start.
REQ-033 First edge after rst rises SHALL process normal inputs.

Verification
REQ-034 Load mem[0]=32'h002081B3, mem[1]=32'h06320813, mem[2]=0; start, instr_rdy=1 -> instr 002081B3 then 06320813 presented, each vld for 1 cycle 2 cycles apart, then halted=1, pc=2.
REQ-035 Same program, instr_rdy=0 for 5 cycles after first vld -> instr=002081B3, pc=0 stable all 5 cycles; advances one FETCH cycle after rdy rises.
REQ-036 Fill all 16 words nonzero, rdy=1 -> 16 instructions, pc 0..15, halt after word 15, pc stays 15, no wrap.
REQ-037 In HOLD at pc=1 assert redir_en, redir_pc=5, instr_rdy=1 -> instr_vld drops, next vld shows mem[5], pc=5.
REQ-038 Drive rst=0 between clock edges during HOLD -> instr_vld, busy, pc go 0 without an edge; ld_en attempted during HOLD beforehand left memory unchanged.
